// File: rtl/hack_pkg.sv
// Shared definitions for the Hack instruction fetch sequencer.
// Holds the sequencer state enum, the C-instruction field positions, the
// reset PC, and the jump decode helpers.
// Optional feature macro: HACK_FETCH_HALT_DETECT_EN (adds the HALT state).
package hack_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned J_GT        = 0;
  localparam int unsigned J_EQ        = 1;
  localparam int unsigned J_LT        = 2;
  localparam int unsigned C_INSTR_BIT = 15;

  localparam logic [PC_W-1:0] PC_RESET = '0;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2
`ifdef HACK_FETCH_HALT_DETECT_EN
    , ST_HALT  = 2'd3
`endif
  } fetch_state_e;

  // A C-instruction with any jump bit set needs the ALU flags to resolve.
  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return instr[C_INSTR_BIT] && (instr[2:0] != 3'b000);
  endfunction

  // Jump condition from the three jump bits and the ALU flags.
  function automatic logic jump_taken(input logic [2:0] jbits,
                                      input logic       zr,
                                      input logic       ng);
    return (jbits[J_LT] & ng) | (jbits[J_EQ] & zr) | (jbits[J_GT] & ~zr & ~ng);
  endfunction

endpackage

// File: rtl/hack_fetch_pc.sv
// Hack program counter: synchronous reset to PC_RESET, load has priority
// over increment, otherwise hold. 16-bit unsigned, increment wraps.
// Ports: clk, reset (sync, active-high), load, inc, in (load value),
//        out (current PC, registered).
module hack_fetch_pc
  import hack_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] in,
  output logic [PC_W-1:0] out
);

  logic [PC_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= PC_RESET;
    end else if (load) begin
      cnt_q <= in;
    end else if (inc) begin
      cnt_q <= cnt_q + PC_W'(1);
    end
  end

  assign out = cnt_q;

endmodule

// File: rtl/hack_fetch.sv
// Hack instruction fetch sequencer. Fetches from ROM with a ready handshake,
// presents each instruction to the execute stage until acked, and resolves
// jumps from zr/ng/a_reg, driving the PC counter's load/inc/in controls.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   rom_req/rom_addr fetch request and address (rom_addr = low bits of pc)
//   rom_ready/rom_data ROM response
//   instr_valid/instr/instr_ack  instruction handoff to execute
//   br_valid/zr/ng/a_reg         jump resolution inputs
//   pc               current program counter
//   halted           self-loop detected (only with HACK_FETCH_HALT_DETECT_EN)
// Macro HACK_FETCH_HALT_DETECT_EN: a taken jump to its own address parks the
// sequencer in HALT until reset; otherwise it simply refetches forever.
module hack_fetch
  import hack_pkg::*;
#(
  parameter int unsigned ROM_DEPTH_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rom_req,
  output logic [ROM_DEPTH_W-1:0] rom_addr,
  input  logic                   rom_ready,
  input  logic [INSTR_W-1:0]     rom_data,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr,
  input  logic                   instr_ack,
  input  logic                   br_valid,
  input  logic                   zr,
  input  logic                   ng,
  input  logic [PC_W-1:0]        a_reg,
  output logic [PC_W-1:0]        pc
`ifdef HACK_FETCH_HALT_DETECT_EN
  ,
  output logic                   halted
`endif
);

  fetch_state_e       state_q;
  logic               rom_req_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instr_q;
`ifdef HACK_FETCH_HALT_DETECT_EN
  logic               halted_q;
`endif

  logic taken;
  logic pc_load;
  logic pc_inc;

  // PC controls are decided on the edge that leaves ISSUE or RESOLVE.
  assign taken   = jump_taken(instr_q[2:0], zr, ng);
  assign pc_load = (state_q == ST_RESOLVE) && br_valid && taken;
  assign pc_inc  = ((state_q == ST_ISSUE) && instr_ack && !is_jump(instr_q)) ||
                   ((state_q == ST_RESOLVE) && br_valid && !taken);

  hack_fetch_pc u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .inc   (pc_inc),
    .in    (a_reg),
    .out   (pc)
  );

  // Sequencer state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      rom_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
`ifdef HACK_FETCH_HALT_DETECT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          rom_req_q <= 1'b1;
          // Only a response to a request we are actually presenting counts;
          // this discards stray ready in the first cycle out of reset.
          if (rom_req_q && rom_ready) begin
            instr_q       <= rom_data;
            rom_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (instr_ack) begin
            instr_valid_q <= 1'b0;
            if (is_jump(instr_q)) begin
              state_q <= ST_RESOLVE;
            end else begin
              state_q   <= ST_FETCH;
              rom_req_q <= 1'b1;
            end
          end
        end
        ST_RESOLVE: begin
          if (br_valid) begin
`ifdef HACK_FETCH_HALT_DETECT_EN
            if (taken && (a_reg == pc)) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q   <= ST_FETCH;
              rom_req_q <= 1'b1;
            end
`else
            state_q   <= ST_FETCH;
            rom_req_q <= 1'b1;
`endif
          end
        end
`ifdef HACK_FETCH_HALT_DETECT_EN
        ST_HALT: begin
          rom_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
        end
`endif
        default: begin
          state_q   <= ST_FETCH;
          rom_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = pc[ROM_DEPTH_W-1:0];
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
`ifdef HACK_FETCH_HALT_DETECT_EN
  assign halted      = halted_q;
`endif

endmodule

// File: tb/tb_hack_fetch.sv
// Self-checking bench for hack_fetch: directed and random instruction
// streams checked against a PC/handshake reference model.
module tb_hack_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ready;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ack;
  logic        br_valid;
  logic        zr;
  logic        ng;
  logic [15:0] a_reg;
  logic [15:0] pc;
`ifdef HACK_FETCH_HALT_DETECT_EN
  logic        halted;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] model_pc;

  always #5 clk = ~clk;

  hack_fetch #(.ROM_DEPTH_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ready   (rom_ready),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ack   (instr_ack),
    .br_valid    (br_valid),
    .zr          (zr),
    .ng          (ng),
    .a_reg       (a_reg),
    .pc          (pc)
`ifdef HACK_FETCH_HALT_DETECT_EN
    ,
    .halted      (halted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Jump decision written as "compare the ALU result against zero".
  function automatic bit model_taken(input logic [15:0] word, input logic z, input logic n);
    int sgn;
    sgn = n ? -1 : (z ? 0 : 1);
    return (sgn < 0 && word[2]) || (sgn == 0 && word[1]) || (sgn > 0 && word[0]);
  endfunction

  // Fetch with wt wait cycles, then issue and ack after ackd cycles.
  // Entered and left on a negedge. Returns whether the word is a jump.
  task automatic fetch_issue(input logic [15:0] word, input int wt, input int ackd,
                             output bit jmp);
    for (int i = 0; i <= wt; i++) begin
      check("fetch_req", 32'(rom_req), 32'd1);
      check("fetch_addr", 32'(rom_addr), 32'(model_pc));
      check("fetch_valid", 32'(instr_valid), 32'd0);
      rom_ready = (i == wt);
      rom_data  = (i == wt) ? word : 16'($urandom);
      instr_ack = 1'($urandom);
      br_valid  = 1'($urandom);
      @(negedge clk);
    end
    rom_ready = 1'b0;
    instr_ack = 1'b0;
    br_valid  = 1'b0;
    check("issue_req_low", 32'(rom_req), 32'd0);
    for (int d = 0; d <= ackd; d++) begin
      check("issue_valid", 32'(instr_valid), 32'd1);
      check("issue_instr", 32'(instr), 32'(word));
      check("issue_pc", 32'(pc), 32'(model_pc));
      instr_ack = (d == ackd);
      rom_ready = 1'($urandom);
      @(negedge clk);
    end
    instr_ack = 1'b0;
    rom_ready = 1'b0;
    check("post_ack_valid", 32'(instr_valid), 32'd0);
    jmp = word[15] && (word[2:0] != 3'b000);
    if (!jmp) begin
      model_pc = model_pc + 16'd1;
      check("inc_pc", 32'(pc), 32'(model_pc));
    end
  endtask

  // Resolve a jump with br_valid after brd cycles. Returns taken.
  task automatic resolve(input logic [15:0] word, input int brd, input logic z,
                         input logic n, input logic [15:0] a_v, output bit tk);
    for (int d = 0; d <= brd; d++) begin
      check("resolve_req", 32'(rom_req), 32'd0);
      check("resolve_valid", 32'(instr_valid), 32'd0);
      check("resolve_pc", 32'(pc), 32'(model_pc));
      br_valid = (d == brd);
      zr       = (d == brd) ? z : 1'($urandom);
      ng       = (d == brd) ? n : 1'($urandom);
      a_reg    = (d == brd) ? a_v : 16'($urandom);
      @(negedge clk);
    end
    br_valid = 1'b0;
    tk = model_taken(word, z, n);
    model_pc = tk ? a_v : model_pc + 16'd1;
    check("jump_pc", 32'(pc), 32'(model_pc));
  endtask

  task automatic run_instr(input logic [15:0] word, input int wt, input int ackd,
                           input int brd, input logic z, input logic n,
                           input logic [15:0] a_v);
    bit jmp;
    bit tk;
    fetch_issue(word, wt, ackd, jmp);
    if (jmp) resolve(word, brd, z, n, a_v, tk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] a_v;
    int          s;
    bit          jmp;

    reset = 1'b1; rom_ready = 1'b1; rom_data = 16'hFFFF; instr_ack = 1'b0;
    br_valid = 1'b0; zr = 1'b0; ng = 1'b0; a_reg = 16'h0;
    model_pc = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(rom_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
`ifdef HACK_FETCH_HALT_DETECT_EN
    check("rst_halted", 32'(halted), 32'd0);
`endif
    reset = 1'b0; rom_ready = 1'b0;
    @(negedge clk);

    // Back-to-back A-instructions: a new fetch every 2 cycles at 0,1,2,...
    for (int k = 0; k < 6; k++) run_instr(16'h0100 + 16'(k), 0, 0, 0, 1'b0, 1'b0, 16'h0);

    // ROM wait states.
    run_instr(16'h1234, 3, 0, 0, 1'b0, 1'b0, 16'h0);

    // JEQ taken with zr=1, then not taken with zr=0.
    run_instr(16'hE302, 0, 0, 0, 1'b1, 1'b0, 16'h0040);
    check("jeq_taken_addr", 32'(rom_addr), 32'h0040);
    run_instr(16'hE302, 0, 1, 2, 1'b0, 1'b0, 16'h0040);
    check("jeq_not_taken_addr", 32'(rom_addr), 32'h0041);

    // Random mix of A- and C-instructions, waits and flags.
    for (int k = 0; k < 40; k++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 1) == 0) w[15] = 1'b0;
      s   = $urandom_range(0, 2);
      a_v = 16'($urandom);
      if (a_v == model_pc) a_v = a_v ^ 16'h0001;
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                (s == 1), (s == 0), a_v);
    end

    // PC wrap: unconditional jump to 0xFFFF, then an A-instruction.
    if (model_pc == 16'hFFFF) run_instr(16'h0001, 0, 0, 0, 1'b0, 1'b0, 16'h0);
    run_instr(16'hE007, 0, 0, 0, 1'b0, 1'b1, 16'hFFFF);
    check("at_ffff", 32'(rom_addr), 32'hFFFF);
    run_instr(16'h0005, 1, 0, 0, 1'b0, 1'b0, 16'h0);
    check("wrap_pc", 32'(pc), 32'h0000);

    // Reset while in RESOLVE with br_valid high.
    run_instr(16'h0007, 0, 0, 0, 1'b0, 1'b0, 16'h0);
    fetch_issue(16'hE007, 0, 0, jmp);
    reset = 1'b1; br_valid = 1'b1; zr = 1'b0; ng = 1'b0; a_reg = 16'h1234; rom_ready = 1'b1;
    @(negedge clk);
    check("rr_pc", 32'(pc), 32'd0);
    check("rr_valid", 32'(instr_valid), 32'd0);
    check("rr_req", 32'(rom_req), 32'd0);
    reset = 1'b0; br_valid = 1'b0; rom_ready = 1'b0;
    model_pc = 16'h0;
    @(negedge clk);
    run_instr(16'h0003, 0, 0, 0, 1'b0, 1'b0, 16'h0);

    // Self-loop jump at 0x0010.
    run_instr(16'hE007, 0, 0, 0, 1'b1, 1'b0, 16'h0010);
    run_instr(16'hEA87, 0, 0, 0, 1'b0, 1'b0, 16'h0010);
`ifdef HACK_FETCH_HALT_DETECT_EN
    for (int k = 0; k < 5; k++) begin
      rom_ready = 1'b1; instr_ack = 1'b1; br_valid = 1'b1; a_reg = 16'h0000;
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(rom_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_pc", 32'(pc), 32'h0010);
      @(negedge clk);
    end
    rom_ready = 1'b0; instr_ack = 1'b0; br_valid = 1'b0;
`else
    for (int k = 0; k < 2; k++) begin
      check("loop_addr", 32'(rom_addr), 32'h0010);
      run_instr(16'hEA87, k, 0, k, 1'b0, 1'b1, 16'h0010);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
